// File: rtl/mem_sched_pkg.sv
// Shared types for the DIMM command scheduler: command encodings, FSM states, latched request.
// Struct field widths follow the scheduler's default geometry.
package mem_sched_pkg;

  localparam int SCHED_BG_W   = 1;
  localparam int SCHED_BA_W   = 2;
  localparam int SCHED_ROW_W  = 8;
  localparam int SCHED_COL_W  = 4;
  localparam int SCHED_LINE_W = 512;

  typedef enum logic [2:0] {
    CMD_READ      = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_PRECHARGE = 3'd3
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE      = 3'd1,
    PRE_WAIT = 3'd2,
    ACT      = 3'd3,
    ACT_WAIT = 3'd4,
    CAS      = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic                    write;
    logic [SCHED_BG_W-1:0]   bg;
    logic [SCHED_BA_W-1:0]   ba;
    logic [SCHED_ROW_W-1:0]  row;
    logic [SCHED_COL_W-1:0]  col;
    logic [SCHED_LINE_W-1:0] wdata;
  } sched_req_t;

endpackage

// File: rtl/bank_state_table.sv
// Per-bank open flag and open-row register with a combinational lookup port.
// Reset closes every bank.
module bank_state_table #(
  parameter int NUM_BANKS = 8,
  parameter int IDX_W     = 3,
  parameter int ROW_BITS  = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [IDX_W-1:0]    lookup_idx,
  input  logic [ROW_BITS-1:0] lookup_row,
  output logic                lookup_open,
  output logic                lookup_row_match,
  input  logic                set_open,
  input  logic                set_closed,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic [ROW_BITS-1:0] upd_row
);

  logic [NUM_BANKS-1:0] open_q;
  logic [ROW_BITS-1:0]  row_q [NUM_BANKS];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else if (set_open) begin
      open_q[upd_idx] <= 1'b1;
      row_q[upd_idx]  <= upd_row;
    end else if (set_closed) begin
      open_q[upd_idx] <= 1'b0;
    end
  end

  assign lookup_open      = open_q[lookup_idx];
  assign lookup_row_match = (row_q[lookup_idx] == lookup_row);

endmodule

// File: rtl/dimm_cmd_scheduler.sv
// Open-page DIMM command scheduler: one request in flight, minimal PRE/ACT/CAS sequence with bus spacing.
// Define CLOSED_PAGE_EN to precharge the bank right after every READ/WRITE.
module dimm_cmd_scheduler
  import mem_sched_pkg::*;
#(
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_write_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
  input  logic [ROW_BITS-1:0]                req_row_in,
  input  logic [COL_BITS-1:0]                req_col_in,
  input  logic [511:0]                       req_wdata_in,
  output logic                               cmd_valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     cmd_bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] cmd_ba_out,
  output logic [ROW_BITS-1:0]                cmd_row_out,
  output logic [COL_BITS-1:0]                cmd_col_out,
  output logic [511:0]                       cmd_wdata_out,
  output logic [15:0]                        hit_count_out
);

  localparam int IDX_W     = $clog2(BANK_GROUPS) + $clog2(BANKS_PER_GROUP);
  localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int PH_MAX    = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY
                                                                      : PRECHARGE_LATENCY;
  localparam int PH_W      = $clog2(PH_MAX + 1);
  localparam int BUS_W     = $clog2(BURST_CYCLES + 1);

  sched_state_e    state_q, state_d;
  sched_req_t      req_q;
  logic [PH_W-1:0]  ph_timer_q;
  logic [BUS_W-1:0] bus_timer_q;
  logic [15:0]      hit_count_q;
  logic             bank_open, row_match, accept, row_hit, cas_go;

  assign accept  = req_valid_in && (state_q == IDLE);
  assign row_hit = bank_open && row_match;
  assign cas_go  = (state_q == CAS) && (bus_timer_q == '0);

  bank_state_table #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W),
    .ROW_BITS  (ROW_BITS)
  ) u_bank_state_table (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .lookup_idx       ({req_bg_in, req_ba_in}),
    .lookup_row       (req_row_in),
    .lookup_open      (bank_open),
    .lookup_row_match (row_match),
    .set_open         (state_q == ACT),
    .set_closed       (state_q == PRE),
    .upd_idx          ({req_q.bg, req_q.ba}),
    .upd_row          (req_q.row)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Wait states exit at timer 1: the issuing state itself is the first latency cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (row_hit)        state_d = CAS;
          else if (bank_open) state_d = PRE;
          else                state_d = ACT;
        end
      end
      PRE:      state_d = PRE_WAIT;
      PRE_WAIT: begin
        if (ph_timer_q <= PH_W'(1)) begin
`ifdef CLOSED_PAGE_EN
          state_d = IDLE;
`else
          state_d = ACT;
`endif
        end
      end
      ACT:      state_d = ACT_WAIT;
      ACT_WAIT: if (ph_timer_q <= PH_W'(1)) state_d = CAS;
      CAS: begin
        if (cas_go) begin
`ifdef CLOSED_PAGE_EN
          state_d = PRE;
`else
          state_d = IDLE;
`endif
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_out = (state_q == IDLE);
    cmd_valid_out = 1'b0;
    cmd_out       = CMD_READ;
    case (state_q)
      PRE: begin
        cmd_valid_out = 1'b1;
        cmd_out       = CMD_PRECHARGE;
      end
      ACT: begin
        cmd_valid_out = 1'b1;
        cmd_out       = CMD_ACTIVATE;
      end
      CAS: begin
        cmd_valid_out = cas_go;
        cmd_out       = req_q.write ? CMD_WRITE : CMD_READ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.write <= req_write_in;
      req_q.bg    <= req_bg_in;
      req_q.ba    <= req_ba_in;
      req_q.row   <= req_row_in;
      req_q.col   <= req_col_in;
      req_q.wdata <= req_wdata_in;
    end
  end

  // The bus timer runs free of the FSM so spacing carries across requests.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ph_timer_q  <= '0;
      bus_timer_q <= '0;
    end else begin
      if (state_q == PRE)        ph_timer_q <= PH_W'(PRECHARGE_LATENCY - 1);
      else if (state_q == ACT)   ph_timer_q <= PH_W'(ACTIVATION_LATENCY - 1);
      else if (ph_timer_q != '0) ph_timer_q <= ph_timer_q - 1'b1;

      if (cas_go)                 bus_timer_q <= BUS_W'(BURST_CYCLES - 1);
      else if (bus_timer_q != '0) bus_timer_q <= bus_timer_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                           hit_count_q <= '0;
    else if (accept && row_hit && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
  end

  assign hit_count_out = hit_count_q;
  assign cmd_bg_out    = req_q.bg;
  assign cmd_ba_out    = req_q.ba;
  assign cmd_row_out   = req_q.row;
  assign cmd_col_out   = req_q.col;
  assign cmd_wdata_out = req_q.wdata;

endmodule

// File: doc/dimm_cmd_scheduler.md
Name: dimm_cmd_scheduler

Overview:
Open-page command scheduler between the memory request queue and the DIMM command sender. Accepts one decoded request at a time (bank group, bank, row, column, read/write). Tracks the open row of every bank. Emits the minimal PRECHARGE / ACTIVATE / READ / WRITE sequence and enforces activation, precharge and data-bus burst spacing.

Parameters:
BANK_GROUPS, 2, number of bank groups
BANKS_PER_GROUP, 4, banks per group
ROW_BITS, 8, row address width
COL_BITS, 4, column address width
ACTIVATION_LATENCY, 8, cycles from ACTIVATE to earliest column command (>=2)
PRECHARGE_LATENCY, 5, cycles from PRECHARGE to earliest ACTIVATE (>=2)
BURST_CYCLES, 8, cycles from one READ/WRITE to the next READ/WRITE (>=2)

Ports:
clk_in  in  1  clock
rst_in  in  1  reset
req_valid_in  in  1  request present
req_ready_out  out  1  scheduler can accept
req_write_in  in  1  1=write, 0=read
req_bg_in  in  $clog2(BANK_GROUPS)  bank group
req_ba_in  in  $clog2(BANKS_PER_GROUP)  bank
req_row_in  in  ROW_BITS  row
req_col_in  in  COL_BITS  column
req_wdata_in  in  512 (8x64)  write line
cmd_valid_out  out  1  command strobe, one cycle per command
cmd_out  out  3  READ=0, WRITE=1, ACTIVATE=2, PRECHARGE=3
cmd_bg_out / cmd_ba_out  out  as req  target bank
cmd_row_out  out  ROW_BITS  row (valid for ACTIVATE)
cmd_col_out  out  COL_BITS  column (valid for READ/WRITE)
cmd_wdata_out  out  512  latched write line (valid with WRITE)
hit_count_out  out  16  saturating row-hit counter

Behaviour:
- Reset: clk_in clock; rst_in asynchronous, active-high. On reset:
  - all banks closed; FSM in IDLE; bus timer 0.
  - cmd_valid_out=0, cmd_out=0, all cmd_* fields 0.
  - hit_count_out=0; req_ready_out=1.
- Reset mid-operation abandons the in-flight request with no further commands.
- req_ready_out=1 only in IDLE. A request is accepted on the cycle valid&&ready is true and latched whole.
- Routing from IDLE, on accept in cycle T (request latched; target state entered at T+1):
  - bank open, row equal -> CAS; hit_count_out increments, saturating at 0xFFFF.
  - bank open, row different -> PRE.
  - bank closed -> ACT.
- Each command is issued in the first cycle of its state: cmd_valid_out=1 for exactly one cycle, all cmd_* fields registered.
- PRE: issue PRECHARGE, mark bank closed, load timer PRECHARGE_LATENCY-1. PRE_WAIT counts to 0, then ACT, so ACTIVATE lands exactly PRECHARGE_LATENCY cycles after PRECHARGE.
- ACT: issue ACTIVATE, record bank open with row, load timer ACTIVATION_LATENCY-1. ACT_WAIT counts to 0, then CAS, so the column command is at the earliest ACTIVATION_LATENCY cycles after ACTIVATE.
- CAS: holds while bus timer != 0 (no command). When 0: issue READ/WRITE, load bus timer BURST_CYCLES-1, go to IDLE next cycle.
- The bus timer decrements every cycle independently of the FSM.
- Latencies with the bus free:
  - hit: CAS at T+1, ready at T+2.
  - closed: CAS at T+1+ACTIVATION_LATENCY.
  - conflict: CAS at T+1+PRECHARGE_LATENCY+ACTIVATION_LATENCY.
- Timers are sized $clog2(max latency+1). The bank index is {bg,ba}. Only one request is in flight, so there are no simultaneous bank-table updates.

Optional Feature:
CLOSED_PAGE_EN
- Defined: after each READ/WRITE the FSM enters PRE for the same bank in the next cycle, then PRE_WAIT, then IDLE. req_ready_out stays 0 until IDLE, so banks are always closed at accept and hit_count_out stays 0.
- Undefined: open-page behaviour as above.

Decomposition:
- Package mem_sched_pkg holds:
  - cmd_e enum (READ/WRITE/ACTIVATE/PRECHARGE encodings);
  - sched_state_e (IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CAS);
  - sched_req_t packed struct (write, bg, ba, row, col, wdata).
- Sub-module bank_state_table:
  - per-bank open flag and row register;
  - combinational lookup (open, row_match) on {bg,ba};
  - set_open / set_closed update ports;
  - async reset clears all.

Test Plan (defaults):
- Reset; read bg0 ba0 row5 col3 accepted cycle T -> ACTIVATE row5 at T+1, READ col3 at T+9, ready at T+10, hit_count_out=0.
- Then write bg0 ba0 row5 col4 accepted T+10 -> stalls in CAS, WRITE at T+17 (bus spacing 8), cmd_wdata_out = input line, hit_count_out=1.
- Bank0 open row5 with bus free; read bg0 ba0 row9 accepted A -> PRECHARGE A+1, ACTIVATE row9 A+6, READ A+14.
- Bank0 open row5; read bg1 ba2 row5 accepted B -> ACTIVATE (not PRECHARGE) B+1 on bank {1,2}; bank0 still hits afterward.
- rst_in pulsed during ACT_WAIT -> cmd_valid_out=0 immediately, ready=1; re-request same row -> ACTIVATE issued (bank closed).
- CLOSED_PAGE_EN: read row5 accepted T -> ACTIVATE T+1, READ T+9, PRECHARGE T+10, ready T+15; repeat same row -> ACTIVATE again, hit_count_out=0.
